// File: rtl/buscaminas_pkg.sv
// buscaminas_pkg: definitions shared between the board generator and the
// minesweeper game FSM.
//   - BOARD_ROWS / BOARD_COLS : board geometry (8x8).
//   - CELL_* : 4-bit cell codes. 0-8 = adjacent-mine count, 10 = marked,
//     11 = bomb.
//   - gen_state_t : board generator FSM states.
package buscaminas_pkg;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 8;

  localparam logic [3:0] CELL_EMPTY  = 4'd0;
  localparam logic [3:0] CELL_MARKED = 4'd10;
  localparam logic [3:0] CELL_BOMB   = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    PLACE,
    COUNT,
    DONE
  } gen_state_t;

endpackage

// File: rtl/buscaminas_board_gen_lfsr.sv
// buscaminas_lfsr16: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// It shifts left, and the feedback enters bit 0.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset (state -> SEED_DEFAULT)
//   load      : load load_val this cycle (has priority over step)
//   load_val  : value to load
//   step      : advance one position
//   lfsr      : current state
module buscaminas_lfsr16 #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (step) begin
      lfsr_d = {lfsr_q[14:0], feedback};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/buscaminas_board_gen.sv
// buscaminas_board_gen: places mines pseudo-randomly on the board, keeping
// one safe cell clear. It then streams every cell code to the game's board
// storage in raster order (x outer, y inner).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin generation (accepted only in IDLE)
//   seed            : LFSR seed (0 selects SEED_DEFAULT)
//   num_mines       : requested mines, clamped to MAX_MINES
//   safe_x, safe_y  : cell that never receives a mine
//   busy            : generation in progress (SEED, PLACE, COUNT)
//   done            : one-cycle pulse after the last write
//   wr_en/wr_x/wr_y/wr_data : board write port (code 0-8 or 11)
//   mines_placed    : mines actually placed
// ROWS and COLS must be powers of two. This lets the low LFSR bits address
// every cell directly.
module buscaminas_board_gen
  import buscaminas_pkg::*;
#(
  parameter int          ROWS         = BOARD_ROWS,
  parameter int          COLS         = BOARD_COLS,
  parameter int          MAX_MINES    = 40,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             seed,
  input  logic [5:0]              num_mines,
  input  logic [$clog2(ROWS)-1:0] safe_x,
  input  logic [$clog2(COLS)-1:0] safe_y,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_x,
  output logic [$clog2(COLS)-1:0] wr_y,
  output logic [3:0]              wr_data,
  output logic [5:0]              mines_placed
);

  localparam int XW    = $clog2(ROWS);
  localparam int YW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int IW    = XW + YW;

  gen_state_t       state_q, state_d;
  logic [CELLS-1:0] mine_q, mine_d;
  logic [5:0]       placed_q, placed_d;
  logic [5:0]       target_q, target_d;
  logic [IW-1:0]    safe_q, safe_d;
  logic             wr_en_q, wr_en_d;
  logic [XW-1:0]    wr_x_q, wr_x_d;
  logic [YW-1:0]    wr_y_q, wr_y_d;
  logic [3:0]       wr_data_q, wr_data_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [15:0]      lfsr_load_val;
  logic [15:0]      lfsr;
  logic [IW-1:0]    cand;
  logic             unused_lfsr_hi;

  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [3:0]       cell_code;
  logic             last_cell;

  buscaminas_lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .step     (lfsr_step),
    .lfsr     (lfsr)
  );

  // The low bits form the candidate {x, y}. Only those bits drive placement.
  assign cand           = lfsr[IW-1:0];
  assign unused_lfsr_hi = ^lfsr[15:IW];

  assign last_cell = (wr_x_q == XW'(ROWS - 1)) && (wr_y_q == YW'(COLS - 1));

  // Cell whose code gets registered at the next edge. This is (0,0) when
  // entering COUNT, otherwise the raster successor of the cell on the port.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    if (state_q == COUNT) begin
      if (wr_y_q == YW'(COLS - 1)) begin
        sel_x = wr_x_q + 1'b1;
      end else begin
        sel_x = wr_x_q;
        sel_y = wr_y_q + 1'b1;
      end
    end
  end

  // Neighbour count of the selected cell. Off-board neighbours are skipped.
  always_comb begin
    int nx;
    int ny;
    logic [3:0] nbr_cnt;
    nx      = 0;
    ny      = 0;
    nbr_cnt = '0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        nx = int'(sel_x) + dx;
        ny = int'(sel_y) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < ROWS && ny >= 0 && ny < COLS) begin
          if (mine_q[IW'(nx * COLS + ny)]) begin
            nbr_cnt = nbr_cnt + 4'd1;
          end
        end
      end
    end
    cell_code = mine_q[{sel_x, sel_y}] ? CELL_BOMB : nbr_cnt;
  end

  always_comb begin
    state_d       = state_q;
    mine_d        = mine_q;
    placed_d      = placed_q;
    target_d      = target_q;
    safe_d        = safe_q;
    wr_en_d       = 1'b0;
    wr_x_d        = '0;
    wr_y_d        = '0;
    wr_data_d     = CELL_EMPTY;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    lfsr_load_val = (seed == 16'd0) ? SEED_DEFAULT : seed;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d  = (num_mines > 6'(MAX_MINES)) ? 6'(MAX_MINES) : num_mines;
          safe_d    = {safe_x, safe_y};
          lfsr_load = 1'b1;
          state_d   = SEED;
        end
      end
      SEED: begin
        mine_d   = '0;
        placed_d = '0;
        state_d  = PLACE;
      end
      PLACE: begin
        if (placed_q == target_q) begin
          // The bitmap is final here, so cell (0,0) can go out right away.
          state_d   = COUNT;
          wr_en_d   = 1'b1;
          wr_x_d    = sel_x;
          wr_y_d    = sel_y;
          wr_data_d = cell_code;
        end else begin
          lfsr_step = 1'b1;
          if (!mine_q[cand] && cand != safe_q) begin
            mine_d[cand] = 1'b1;
            placed_d     = placed_q + 6'd1;
          end
        end
      end
      COUNT: begin
        if (last_cell) begin
          state_d = DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_x_d    = sel_x;
          wr_y_d    = sel_y;
          wr_data_d = cell_code;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mine_q    <= '0;
      placed_q  <= '0;
      target_q  <= '0;
      safe_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mine_q    <= mine_d;
      placed_q  <= placed_d;
      target_q  <= target_d;
      safe_q    <= safe_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy         = (state_q == SEED) || (state_q == PLACE) || (state_q == COUNT);
  assign done         = (state_q == DONE);
  assign wr_en        = wr_en_q;
  assign wr_x         = wr_x_q;
  assign wr_y         = wr_y_q;
  assign wr_data      = wr_data_q;
  assign mines_placed = placed_q;

endmodule

// File: tb/tb_buscaminas_board_gen.sv
module tb_buscaminas_board_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [5:0]  num_mines;
  logic [2:0]  safe_x;
  logic [2:0]  safe_y;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [2:0]  wr_x;
  logic [2:0]  wr_y;
  logic [3:0]  wr_data;
  logic [5:0]  mines_placed;

  int n_cmp = 0;
  int n_bad = 0;

  // Capture of one generation run
  logic [2:0] cap_x [64];
  logic [3:0] cap_d [64];
  logic [2:0] cap_y [64];
  int         cap_n;
  int         done_cyc;
  int         first_wr_cyc;
  logic       busy0;

  buscaminas_board_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .num_mines    (num_mines),
    .safe_x       (safe_x),
    .safe_y       (safe_y),
    .busy         (busy),
    .done         (done),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .mines_placed (mines_placed)
  );

  always #5 clk = ~clk;

  // Starts one generation and records the write stream until done or the
  // cycle budget runs out. Cycle k = k-th period after the accepting edge.
  task automatic run_gen(input logic [15:0] s, input logic [5:0] n,
                         input logic [2:0] sx, input logic [2:0] sy,
                         input bit hold, input int budget);
    @(negedge clk);
    seed = s; num_mines = n; safe_x = sx; safe_y = sy; start = 1'b1;
    @(posedge clk);
    cap_n = 0; done_cyc = -1; first_wr_cyc = -1; busy0 = 1'b0;
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (k == 0) busy0 = busy;
      if (wr_en) begin
        if (cap_n < 64) begin
          cap_x[cap_n] = wr_x; cap_y[cap_n] = wr_y; cap_d[cap_n] = wr_data;
        end
        if (first_wr_cyc < 0) first_wr_cyc = k;
        cap_n++;
      end
      if (done) done_cyc = k;
    end
    $display("gen seed=%h mines=%0d safe=(%0d,%0d) writes=%0d first_wr@%0d done@%0d placed=%0d",
             s, n, sx, sy, cap_n, first_wr_cyc, done_cyc, mines_placed);
  endtask

  function automatic int ref_code(logic [63:0] bm, int x, int y);
    int c;
    c = 0;
    if (bm[x*8+y]) return 11;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (!(dx == 0 && dy == 0) && x+dx >= 0 && x+dx < 8 && y+dy >= 0 && y+dy < 8)
          if (bm[(x+dx)*8+(y+dy)]) c++;
    return c;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; seed = '0; num_mines = '0; safe_x = '0; safe_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, wr_en, wr_x, wr_y, wr_data, mines_placed} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h need 0", {busy, done, wr_en, wr_x, wr_y, wr_data, mines_placed});
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_mines;
    int bad_order;
    int bad_data;
    run_gen(16'h0001, 6'd0, 3'd0, 3'd0, 1'b0, 300);
    n_cmp++;
    if (busy0 !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %b need 1", busy0); end
    n_cmp++;
    if (cap_n !== 64) begin n_bad++; $display("FAIL zero_writes: got %0d need 64", cap_n); end
    n_cmp++;
    if (first_wr_cyc !== 2) begin n_bad++; $display("FAIL zero_first_wr: got %0d need 2", first_wr_cyc); end
    n_cmp++;
    if (done_cyc !== 66) begin n_bad++; $display("FAIL zero_done_cycle: got %0d need 66", done_cyc); end
    n_cmp++;
    if (mines_placed !== 6'd0) begin n_bad++; $display("FAIL zero_placed: got %0d need 0", mines_placed); end
    bad_order = 0; bad_data = 0;
    for (int i = 0; i < 64 && i < cap_n; i++) begin
      if (cap_x[i] !== 3'(i / 8) || cap_y[i] !== 3'(i % 8)) bad_order++;
      if (cap_d[i] !== 4'd0) bad_data++;
    end
    n_cmp++;
    if (bad_order != 0) begin n_bad++; $display("FAIL zero_raster_order: got %0d wrong cells need 0", bad_order); end
    n_cmp++;
    if (bad_data != 0) begin n_bad++; $display("FAIL zero_data: got %0d nonzero cells need 0", bad_data); end
  endtask

  // seed low bits 6'b011_011 -> first candidate (3,3)
  task automatic test_center_mine;
    int exp;
    int bad;
    run_gen(16'h001B, 6'd1, 3'd0, 3'd0, 1'b0, 300);
    n_cmp++;
    if (cap_n !== 64) begin n_bad++; $display("FAIL center_writes: got %0d need 64", cap_n); end
    n_cmp++;
    if (done_cyc !== 67) begin n_bad++; $display("FAIL center_done_cycle: got %0d need 67", done_cyc); end
    bad = 0;
    for (int i = 0; i < 64 && i < cap_n; i++) begin
      exp = (i/8 == 3 && i%8 == 3) ? 11 : (i/8 >= 2 && i/8 <= 4 && i%8 >= 2 && i%8 <= 4) ? 1 : 0;
      if (cap_d[i] !== 4'(exp)) begin
        bad++;
        $display("FAIL center_cell(%0d,%0d): got %0d need %0d", i/8, i%8, cap_d[i], exp);
      end
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL center_board: got %0d wrong cells need 0", bad); end
  endtask

  // seed low bits 0 -> first candidate (0,0); safe cell elsewhere
  task automatic test_corner_mine;
    int exp;
    int bad;
    run_gen(16'h0040, 6'd1, 3'd7, 3'd7, 1'b0, 300);
    n_cmp++;
    if (cap_n !== 64) begin n_bad++; $display("FAIL corner_writes: got %0d need 64", cap_n); end
    bad = 0;
    for (int i = 0; i < 64 && i < cap_n; i++) begin
      exp = (i == 0) ? 11 : (i/8 <= 1 && i%8 <= 1) ? 1 : 0;
      if (cap_d[i] !== 4'(exp)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL corner_board: got %0d wrong cells need 0", bad); end
    n_cmp++;
    if (cap_d[63] !== 4'd0 || cap_d[7] !== 4'd0 || cap_d[56] !== 4'd0)
      begin n_bad++; $display("FAIL corner_wrap: got %0d/%0d/%0d need 0/0/0", cap_d[63], cap_d[7], cap_d[56]); end
    @(negedge clk);
    n_cmp++;
    if (mines_placed !== 6'd1) begin n_bad++; $display("FAIL corner_placed_hold: got %0d need 1", mines_placed); end
  endtask

  task automatic test_clamp;
    logic [63:0] bm;
    logic [15:0] l;
    int placed;
    int bombs;
    int bad;
    bm = '0; l = 16'h1234; placed = 0;
    for (int it = 0; it < 100000 && placed < 40; it++) begin
      if (!bm[l[5:0]] && l[5:0] != 6'd36) begin bm[l[5:0]] = 1'b1; placed++; end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    run_gen(16'h1234, 6'd63, 3'd4, 3'd4, 1'b0, 3000);
    n_cmp++;
    if (done_cyc < 0) begin n_bad++; $display("FAIL clamp_timeout: got no done need done"); end
    n_cmp++;
    if (mines_placed !== 6'd40) begin n_bad++; $display("FAIL clamp_placed: got %0d need 40", mines_placed); end
    bombs = 0; bad = 0;
    for (int i = 0; i < 64 && i < cap_n; i++) begin
      if (cap_d[i] == 4'd11) bombs++;
      if (cap_d[i] !== 4'(ref_code(bm, i/8, i%8))) bad++;
    end
    n_cmp++;
    if (bombs != 40) begin n_bad++; $display("FAIL clamp_bombs: got %0d need 40", bombs); end
    n_cmp++;
    if (cap_d[36] === 4'd11) begin n_bad++; $display("FAIL clamp_safe: got 11 need not 11"); end
    n_cmp++;
    if (bad != 0 || cap_n != 64) begin n_bad++; $display("FAIL clamp_board: got %0d wrong of %0d writes need 0 of 64", bad, cap_n); end
  endtask

  task automatic test_reset_mid_count;
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    seed = 16'hBEEF; num_mines = 6'd3; safe_x = 3'd0; safe_y = 3'd0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en && wr_x == 3'd2 && wr_y == 3'd4) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL rstmid_reach_cell20: got timeout need cell 20"); end
    n_cmp++;
    if (mines_placed !== 6'd3) begin n_bad++; $display("FAIL rstmid_placed: got %0d need 3", mines_placed); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, wr_en, wr_x, wr_y, wr_data, mines_placed} !== 20'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h need 0", {busy, done, wr_en, wr_x, wr_y, wr_data, mines_placed});
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset asserted during COUNT at cell 20");
    run_gen(16'h0001, 6'd0, 3'd0, 3'd0, 1'b0, 300);
    n_cmp++;
    if (cap_n !== 64 || done_cyc !== 66)
      begin n_bad++; $display("FAIL rstmid_rerun: got %0d writes done@%0d need 64 done@66", cap_n, done_cyc); end
  endtask

  task automatic test_back_to_back;
    bit fin;
    run_gen(16'h0001, 6'd0, 3'd0, 3'd0, 1'b1, 300);
    n_cmp++;
    if (cap_n !== 64 || done_cyc !== 66)
      begin n_bad++; $display("FAIL hold_first: got %0d writes done@%0d need 64 done@66", cap_n, done_cyc); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL hold_idle_gap: got busy=%b wr_en=%b need 0/0", busy, wr_en); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_restart: got busy=%b need 1", busy); end
    start = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      if (done) fin = 1'b1;
    end
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL hold_second_done: got timeout need done"); end
    $display("held start: restart observed two cycles after done");
  endtask

  initial begin
    test_reset;
    test_zero_mines;
    test_center_mine;
    test_corner_mine;
    test_clamp;
    test_reset_mid_count;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buscaminas_board_gen.md
Name: buscaminas_board_gen

Overview:
- Upstream stage of the minesweeper game FSM. On start, it places N mines pseudo-randomly on the 8x8 board using an LFSR. It never places a mine on one protected "safe" cell.
- It then streams every cell's final code into the game's board storage over a write port. Codes: 0-8 = adjacent-mine count, 11 = bomb. This matches the game FSM encoding, where 10 = marked.
- It raises done once the whole board has been written.

Parameters:
- ROWS, 8, board rows; x index width is $clog2(ROWS).
- COLS, 8, board columns; y index width is $clog2(COLS).
- MAX_MINES, 40, upper clamp on the requested mine count.
- SEED_DEFAULT, 16'hACE1, LFSR value used when seed input is 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin generation; sampled only in IDLE.
- seed  in  16  LFSR seed; captured on accepted start.
- num_mines  in  6  requested mine count; captured on accepted start.
- safe_x  in  3  row of the cell that must not hold a mine; captured on accepted start.
- safe_y  in  3  column of the cell that must not hold a mine; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last cell write.
- wr_en  out  1  board write strobe.
- wr_x  out  3  board write row.
- wr_y  out  3  board write column.
- wr_data  out  4  cell code (0-8 or 11).
- mines_placed  out  6  number of mines actually placed; stable after done until the next start.

Behaviour:
- Reset, asynchronous and applicable in any state including mid-generation:
  - state = IDLE, mine bitmap cleared, lfsr = SEED_DEFAULT.
  - All outputs 0.
  - Any partially written board is abandoned; the consumer must not trust the board until the next done.
- States: IDLE -> SEED -> PLACE -> COUNT -> DONE -> IDLE.
- IDLE:
  - start=1 is accepted at a clock edge.
  - On acceptance, register target = min(num_mines, MAX_MINES), the safe cell, and lfsr = (seed==0 ? SEED_DEFAULT : seed).
  - Next state is SEED.
- SEED (1 cycle):
  - Clear the 64-bit mine bitmap and set mines_placed = 0.
  - Next state is PLACE.
- PLACE (one candidate per cycle):
  - If mines_placed == target, go to COUNT. No LFSR step happens in that cycle.
  - Otherwise the candidate cell is x = lfsr[5:3], y = lfsr[2:0].
  - If the candidate is not already a mine and is not the safe cell, set its bitmap bit and increment mines_placed.
  - The LFSR steps every PLACE cycle in which the target is not yet met.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0. Its maximal period covers every 6-bit low pattern, so PLACE always terminates because MAX_MINES <= 63.
- COUNT (exactly ROWS*COLS cycles):
  - Raster order: x outer, y inner, starting at (0,0).
  - Each cycle drives wr_en=1, wr_x, wr_y, and wr_data = 11 if the cell is a mine, else the number of mine neighbours among the 8 surrounding cells.
  - Neighbours outside the board are excluded; there is no wrap-around at edges or corners.
  - The neighbour count is combinational from the bitmap, and outputs are registered.
- DONE (1 cycle): done=1, wr_en=0, busy=0, then IDLE.
- busy = 1 in SEED, PLACE and COUNT.
- start while busy or in DONE is ignored and not queued.
- Latency with target=0: start accepted at edge E, then SEED, then PLACE, then 64 COUNT cycles. wr_en is high for cycles E+2..E+65, and done is high in cycle E+66. Each placed mine adds at least one PLACE cycle.
- num_mines > MAX_MINES: clamped to MAX_MINES, and mines_placed reports the clamped value.

Decomposition:
- Package buscaminas_pkg:
  - Constants CELL_EMPTY=0, CELL_MARKED=10, CELL_BOMB=11, BOARD_ROWS=8, BOARD_COLS=8.
  - Enum gen_state_t {IDLE, SEED, PLACE, COUNT, DONE}.
  - This package is shared with the game FSM.
- Sub-module buscaminas_lfsr16: load and step controls, 16-bit state output.

Test Plan:
- num_mines=0, seed=1, start pulse -> 64 writes in raster order, all wr_data=0; done pulses in cycle E+66; mines_placed=0.
- num_mines=1, safe=(0,0), seed chosen so the first candidate is (3,3) -> (3,3)=11; its 8 neighbours =1; all other cells =0; exactly 64 writes.
- Corner mine forced at (0,0) via a known seed -> (0,1), (1,0), (1,1) =1; no write reports a wrap-around count at (7,7), (0,7) or (7,0).
- num_mines=63 -> clamped to 40; mines_placed=40; bitmap popcount 40; safe cell never 11; sum of 11s in the write stream = 40.
- Assert rst during COUNT at cell 20 -> all outputs 0 on the same edge; state IDLE; a following start runs a full 64-write generation.
- start held high throughout generation -> no restart while busy; a new generation begins only after returning to IDLE (one cycle after done).
